// File: rtl/secure_serdes_cipher.sv
// secure_serdes_cipher: serial-in A/B cipher with four modes, parallel result and re-serialised output
module secure_serdes_cipher #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int ROT       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic [WIDTH-1:0] cipher,
  output logic             parity,
  output logic             valid,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CALC, SEROUT} state_t;
  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] a_sr, b_sr, o_sr, x, rotl, res;
  logic             valid_q;
  logic             last;
  assign last = cnt == CW'(WIDTH - 1);
  assign x    = a_sr ^ b_sr;
  assign rotl = (ROT == 0) ? x : (x << ROT) | (x >> (WIDTH - ROT));
  assign res  = mode_q == 2'd0 ? x :
                mode_q == 2'd1 ? ~x :
                mode_q == 2'd2 ? a_sr + b_sr : rotl;
  // state register; all state freezes while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (ena) state <= state_nx;
  end
  // next-state: the counter paces both the shift-in and shift-out phases
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SHIFT : IDLE;
      SHIFT:   state_nx = last ? CALC : SHIFT;
      CALC:    state_nx = SEROUT;
      SEROUT:  state_nx = last ? IDLE : SEROUT;
      default: state_nx = IDLE;
    endcase
  end
  // outputs: handshake pulses are masked while the clock enable is low
  always_comb begin
    busy      = state != IDLE;
    ser_valid = (state == SEROUT) && ena;
    valid     = valid_q && ena;
    ser_out   = (MSB_FIRST != 0) ? o_sr[WIDTH-1] : o_sr[0];
  end
  // datapath: shift-in, result capture and shift-out, advancing only on enabled edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mode_q  <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      o_sr    <= '0;
      cipher  <= '0;
      parity  <= 1'b0;
      valid_q <= 1'b0;
    end else if (ena) begin
      valid_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_q <= mode;
          a_sr   <= '0;
          b_sr   <= '0;
          cnt    <= '0;
        end
        SHIFT: begin
          a_sr <= (MSB_FIRST != 0) ? {a_sr[WIDTH-2:0], a_bit} : {a_bit, a_sr[WIDTH-1:1]};
          b_sr <= (MSB_FIRST != 0) ? {b_sr[WIDTH-2:0], b_bit} : {b_bit, b_sr[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
        end
        CALC: begin
          cipher  <= res;
          parity  <= ^res;
          valid_q <= 1'b1;
          o_sr    <= res;
          cnt     <= '0;
        end
        default: begin
          o_sr <= (MSB_FIRST != 0) ? o_sr << 1 : o_sr >> 1;
          cnt  <= cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_secure_serdes_cipher.sv
// tb_secure_serdes_cipher: scoreboard bench for the 8-bit MSB-first and 16-bit LSB-first variants
module tb_secure_serdes_cipher;
  logic        clk = 0, rst_n = 0, ena = 1, start = 0, a_bit = 0, b_bit = 0;
  logic [1:0]  mode = 0;
  logic [7:0]  cipher;
  logic        parity, valid, ser_out, ser_valid, busy;
  logic        start2 = 0, a2 = 0, b2 = 0;
  logic [1:0]  mode2 = 0;
  logic [15:0] cipher2;
  logic        parity2, valid2, ser_out2, ser_valid2, busy2;

  secure_serdes_cipher dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode),
    .a_bit(a_bit), .b_bit(b_bit), .cipher(cipher), .parity(parity),
    .valid(valid), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy)
  );
  secure_serdes_cipher #(.WIDTH(16), .MSB_FIRST(0), .ROT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2), .mode(mode2),
    .a_bit(a2), .b_bit(b2), .cipher(cipher2), .parity(parity2),
    .valid(valid2), .ser_out(ser_out2), .ser_valid(ser_valid2), .busy(busy2)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    x = a ^ b;
    case (m)
      2'd0:    return x;
      2'd1:    return ~x;
      2'd2:    return a + b;
      default: return {x[4:0], x[7:5]};
    endcase
  endfunction

  logic [7:0]  q[$];
  logic [15:0] q2[$];
  logic [7:0]  ser_exp = 0;
  logic [15:0] ser_exp2 = 0;
  int ser_n = 0, ser_n2 = 0, vcyc = 0, vcyc2 = 0;

  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) chk("spurious_valid", 32'(valid), 0);
      else begin
        ser_exp = q.pop_front();
        chk("cipher", 32'(cipher), 32'(ser_exp));
        chk("parity", 32'(parity), 32'(^ser_exp));
        ser_n = 0;
        vcyc = cyc;
      end
    end
    if (ser_valid) begin
      if (ser_n < 8) chk("ser_bit", 32'(ser_out), 32'(ser_exp[7-ser_n]));
      ser_n++;
    end
  end

  always @(negedge clk) begin
    if (valid2) begin
      if (q2.size() == 0) chk("spurious_valid2", 32'(valid2), 0);
      else begin
        ser_exp2 = q2.pop_front();
        chk("cipher2", 32'(cipher2), 32'(ser_exp2));
        chk("parity2", 32'(parity2), 32'(^ser_exp2));
        ser_n2 = 0;
        vcyc2 = cyc;
      end
    end
    if (ser_valid2) begin
      if (ser_n2 < 16) chk("ser_bit2", 32'(ser_out2), 32'(ser_exp2[ser_n2]));
      ser_n2++;
    end
  end

  task automatic xact(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input int stall_at = -1, input bit poke = 0);
    int t0;
    start = 1;
    mode = m;
    q.push_back(exp);
    step();
    t0 = cyc;
    start = 0;
    mode = ~m;
    for (int e = 1; e <= 17; e++) begin
      a_bit = (e <= 8) ? a[8-e] : 1'($urandom);
      b_bit = (e <= 8) ? b[8-e] : 1'($urandom);
      start = poke && (e == 4 || e == 12);
      step();
      start = 0;
      if (e == stall_at) begin
        ena = 0;
        repeat (3) step();
        ena = 1;
      end
      if (e == 16) chk("busy_high_E16", 32'(busy), 1);
      if (e == 17) chk("busy_low_E17", 32'(busy), 0);
    end
    chk("ser_len", ser_n, 8);
    chk("latency", vcyc - t0, 9 + ((stall_at > 0 && stall_at <= 9) ? 3 : 0));
    chk("sb_drained", q.size(), 0);
  endtask

  initial begin
    logic [7:0] a, b;
    logic [1:0] m;
    logic [15:0] a16, b16;
    int t0;
    repeat (2) step();
    chk("rst_cipher", 32'(cipher), 0);
    chk("rst_parity", 32'(parity), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ser_out", 32'(ser_out), 0);
    chk("rst_ser_valid", 32'(ser_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1;
    step();
    xact(2'd0, 8'hA5, 8'h3C, 8'h99);
    xact(2'd1, 8'hA5, 8'h3C, 8'h66);
    xact(2'd2, 8'hA5, 8'h3C, 8'hE1);
    xact(2'd3, 8'hA5, 8'h3C, 8'hCC);
    xact(2'd2, 8'hFF, 8'h02, 8'h01);
    xact(2'd0, 8'hA5, 8'h3C, 8'h99, -1, 1);
    xact(2'd0, 8'hA5, 8'h3C, 8'h99, 4);
    xact(2'd1, 8'h5A, 8'h0F, 8'hAA, 9);
    start = 1;
    mode = 2'd0;
    step();
    start = 0;
    for (int e = 1; e <= 5; e++) begin
      a_bit = 1'(8'hA5 >> (8 - e));
      b_bit = 1'(8'h3C >> (8 - e));
      step();
    end
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("midrst_cipher", 32'(cipher), 0);
    chk("midrst_parity", 32'(parity), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_ser_out", 32'(ser_out), 0);
    chk("midrst_ser_valid", 32'(ser_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    step();
    rst_n = 1;
    repeat (3) step();
    chk("post_rst_idle", 32'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      m = 2'($urandom);
      xact(m, a, b, model(m, a, b));
    end
    a16 = 16'h1234;
    b16 = 16'hFFFF;
    start2 = 1;
    mode2 = 2'd0;
    q2.push_back(16'hEDCB);
    step();
    t0 = cyc;
    start2 = 0;
    mode2 = 2'd3;
    for (int e = 1; e <= 33; e++) begin
      a2 = (e <= 16) ? a16[e-1] : 1'b0;
      b2 = (e <= 16) ? b16[e-1] : 1'b0;
      step();
      if (e == 32) chk("busy2_high", 32'(busy2), 1);
      if (e == 33) chk("busy2_low", 32'(busy2), 0);
    end
    chk("ser_len2", ser_n2, 16);
    chk("latency2", vcyc2 - t0, 17);
    chk("sb2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
